// File: rtl/mips_core_pkg.sv
// Shared core types: address/data words, cache port payloads and store-buffer entries.
package mips_core_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] Address;
  typedef logic [DATA_WIDTH-1:0] Data;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } MemAccessType;

  typedef struct packed {
    logic valid;
    Data  data;
  } cache_output_t;

  typedef struct packed {
    logic   valid;
    Address addr;
    Data    data;
  } store_buffer_entry_t;

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_ISSUE = 1'b1
  } sb_drain_state_t;

endpackage

// File: rtl/d_cache_input_ifc.sv
// Request bundle presented to a D-cache port of memory_unit.
interface d_cache_input_ifc;
  import mips_core_pkg::*;

  logic         valid;
  MemAccessType mem_action;
  Address       addr;
  Address       addr_next;
  Data          data;

  modport in  (input  valid, mem_action, addr, addr_next, data);
  modport out (output valid, mem_action, addr, addr_next, data);
endinterface

// File: rtl/store_buffer_fwd_match.sv
// Youngest-match search of the store buffer for store-to-load forwarding.
module store_buffer_fwd_match
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  store_buffer_entry_t [DEPTH-1:0] entries,
  input  logic [$clog2(DEPTH)-1:0]        head,
  input  Address                          fwd_addr,
  output logic                            fwd_hit,
  output Data                             fwd_data
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [IW-1:0] idx;

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + IW'(k);
      if (entries[idx].valid && (entries[idx].addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: queues committed stores, drains them one at a time to the
// memory_unit store port and forwards word data to the load path.
module store_buffer
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  Address                   push_addr,
  input  Data                      push_data,
  output logic                     push_ready,
  d_cache_input_ifc.out            store_input,
  input  cache_output_t            store_output,
  input  Address                   fwd_addr,
  output logic                     fwd_hit,
  output Data                      fwd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  store_buffer_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_next;
  logic [PW-1:0]   tail_next;
  logic [IW-1:0]   head_idx;
  logic [IW-1:0]   tail_idx;
  logic            full;
  logic            do_push;
  logic            do_pop;
  sb_drain_state_t state;

  assign head_idx = head[IW-1:0];
  assign tail_idx = tail[IW-1:0];
  assign full     = (head_idx == tail_idx) && (head[IW] != tail[IW]);
  assign empty    = (head == tail);
  assign count    = tail - head;

  assign push_ready = !full;
  assign do_push    = push_valid && !full;
  assign do_pop     = store_output.valid && !empty;

  always_comb begin
    head_next = head;
    tail_next = tail;
    if (do_pop)  head_next = head + PW'(1);
    if (do_push) tail_next = tail + PW'(1);
  end

  // Pointer/entry update and drain state; state tracks whether a head entry is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      entries <= '0;
      state   <= SB_IDLE;
    end else begin
      if (do_push) begin
        entries[tail_idx] <= '{valid: 1'b1, addr: push_addr, data: push_data};
      end
      if (do_pop) begin
        entries[head_idx].valid <= 1'b0;
      end
      head  <= head_next;
      tail  <= tail_next;
      state <= (head_next != tail_next) ? SB_ISSUE : SB_IDLE;
    end
  end

  // Request drops in the completion cycle so memory_unit never re-issues the finishing store.
  assign store_input.valid      = (state == SB_ISSUE) && !store_output.valid;
  assign store_input.mem_action = WRITE;
  assign store_input.addr       = entries[head_idx].addr;
  assign store_input.addr_next  = entries[head_idx].addr;
  assign store_input.data       = entries[head_idx].data;

  logic unused_store_data;
  assign unused_store_data = ^store_output.data;

  store_buffer_fwd_match #(
    .DEPTH(DEPTH)
  ) u_fwd_match (
    .entries  (entries),
    .head     (head_idx),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a scoreboard of pending stores in program order.
module tb_store_buffer;
  import mips_core_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    Address addr;
    Data    data;
  } sb_item_t;

  logic          clk;
  logic          rst_n;
  logic          push_valid;
  Address        push_addr;
  Data           push_data;
  logic          push_ready;
  cache_output_t store_output;
  Address        fwd_addr;
  logic          fwd_hit;
  Data           fwd_data;
  logic          empty;
  logic [2:0]    count;

  d_cache_input_ifc store_input ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid   (push_valid),
    .push_addr    (push_addr),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .store_input  (store_input),
    .store_output (store_output),
    .fwd_addr     (fwd_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .empty        (empty),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sb_item_t sb[$];
  int       exp_count;
  int       total;
  int       passed;
  int       failed;
  int       writes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending store to the load address, from the scoreboard.
  task automatic model_fwd(input Address a, output logic hit, output Data d);
    hit = 1'b0;
    d   = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].addr == a) begin
        hit = 1'b1;
        d   = sb[i].data;
        break;
      end
    end
  endtask

  // One clock: drive at posedge+1, check at posedge+2, commit at the next posedge.
  task automatic cycle(input logic pv, input Address a, input Data d, input logic comp);
    logic exp_hit;
    Data  exp_fd;
    logic accept;
    push_valid         = pv;
    push_addr          = a;
    push_data          = d;
    store_output.valid = comp;
    store_output.data  = 32'hDEAD_BEEF;
    #1;
    check("count", 32'(count), 32'(exp_count));
    check("empty", 32'(empty), 32'(exp_count == 0));
    check("push_ready", 32'(push_ready), 32'(exp_count < DEPTH));
    check("issue_valid", 32'(store_input.valid), 32'(exp_count != 0 && !comp));
    if (exp_count != 0) begin
      check("issue_addr", store_input.addr, sb[0].addr);
      check("issue_addr_next", store_input.addr_next, sb[0].addr);
      check("issue_data", store_input.data, sb[0].data);
      check("issue_action", 32'(store_input.mem_action), 32'(WRITE));
    end
    model_fwd(fwd_addr, exp_hit, exp_fd);
    check("fwd_hit", 32'(fwd_hit), 32'(exp_hit));
    check("fwd_data", fwd_data, exp_fd);
    accept = pv && (exp_count < DEPTH);
    if (comp && exp_count != 0) begin
      void'(sb.pop_front());
      exp_count--;
      writes++;
    end
    if (accept) begin
      sb.push_back('{addr: a, data: d});
      exp_count++;
    end
    @(posedge clk);
    #1;
    push_valid         = 1'b0;
    store_output.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
  endtask

  task automatic push(input Address a, input Data d);
    cycle(1'b1, a, d, 1'b0);
  endtask

  task automatic complete();
    cycle(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    total = 0; passed = 0; failed = 0; writes = 0; exp_count = 0;
    rst_n = 1'b0;
    push_valid = 1'b0; push_addr = '0; push_data = '0;
    store_output = '0;
    fwd_addr = 32'h100;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_push_ready", 32'(push_ready), 32'd1);
    check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    check("rst_fwd_data", fwd_data, 32'd0);
    check("rst_issue_valid", 32'(store_input.valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-cycle with three entries held
    push(32'h010, 32'h1); push(32'h014, 32'h2); push(32'h018, 32'h3);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_issue_valid", 32'(store_input.valid), 32'd0);
    check("midrst_fwd_hit", 32'(fwd_hit), 32'd0);
    sb.delete();
    exp_count = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Single store held stable while memory_unit is busy, then completed
    push(32'h100, 32'h11);
    idle(10);
    complete();
    idle(1);

    // Fill, then push rejected in the same cycle as a completion
    fwd_addr = 32'h999;
    push(32'h20, 32'hA0); push(32'h24, 32'hA1); push(32'h28, 32'hA2); push(32'h2C, 32'hA3);
    cycle(1'b1, 32'h999, 32'h99, 1'b1);
    idle(1);
    complete(); complete(); complete();
    complete();
    idle(1);

    // Forwarding picks the youngest match and survives the older entry's completion
    fwd_addr = 32'h200;
    push(32'h200, 32'hAA);
    push(32'h200, 32'hBB);
    idle(1);
    complete();
    idle(1);
    complete();
    idle(1);
    check("fwd_done_hit", 32'(fwd_hit), 32'd0);
    check("fwd_done_data", fwd_data, 32'd0);

    // Wrap-around with push and pop in the same cycle
    fwd_addr = 32'h308;
    push(32'h300, 32'h50); push(32'h304, 32'h51);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h308 + 32'(i * 4), 32'h60 + 32'(i), 1'b1);
    end
    complete(); complete();
    idle(1);

    // Stores wait behind a burst of loads, then each is written once in order
    fwd_addr = 32'h404;
    writes = 0;
    push(32'h400, 32'h70); push(32'h404, 32'h71);
    idle(5);
    complete();
    idle(2);
    complete();
    idle(1);
    check("int_writes", 32'(writes), 32'd2);
    check("int_sb_drained", 32'(sb.size()), 32'd0);
    check("int_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
